// File: rtl/nco_sweep_ctrl_if.sv
// Tuning-word handshake between the sweep sequencer (master) and the NCO (slave).
interface nco_sweep_ctrl_if #(
    parameter int unsigned FTW_W = 32
);
    logic [FTW_W-1:0] ftw_out;
    logic             ftw_valid;
    logic             ftw_ready;

    modport master (output ftw_out, output ftw_valid, input ftw_ready);
    modport slave  (input ftw_out, input ftw_valid, output ftw_ready);
endinterface

// File: rtl/nco_sweep_ctrl.sv
// Frequency-sweep sequencer: steps the NCO tuning word from start to stop in fixed increments,
// holding each word for a dwell time after the NCO accepts it.
// Optional build macro NCO_SWEEP_PINGPONG_EN: continuous sweeps reverse at each end point
// instead of jumping back to the start word.
module nco_sweep_ctrl #(
    parameter int unsigned FTW_W   = 32,
    parameter int unsigned DWELL_W = 24,
    parameter int unsigned CNT_W   = 16
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic               start,
    input  logic               stop,
    input  logic [FTW_W-1:0]   ftw_start,
    input  logic [FTW_W-1:0]   ftw_stop,
    input  logic [FTW_W-1:0]   ftw_step,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               continuous,
    nco_sweep_ctrl_if.master   ftw_bus,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   step_cnt
);

    typedef enum logic [1:0] {StIdle, StWaitAck, StDwell} state_e;

    state_e             state_q, state_d;
    logic [FTW_W-1:0]   ftw_q, ftw_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
    logic               done_q, done_d;

    // Programme captured at start so input changes mid-sweep are ignored.
    logic [FTW_W-1:0]   start_q, stop_q, step_q;
    logic [DWELL_W-1:0] dwell_q;
    logic               cont_q;
    logic               load;

    logic [FTW_W:0]     up_sum;
    logic [FTW_W-1:0]   up_word;
    logic               degenerate;
    logic               at_top;

`ifdef NCO_SWEEP_PINGPONG_EN
    logic               dir_down_q, dir_down_d;
    logic [FTW_W:0]     dn_diff;
    logic [FTW_W-1:0]   dn_word;
`endif

    assign load = (state_q == StIdle) && start && !stop;

    // Next-word arithmetic; the extra bit catches overflow, which then clamps to the stop word.
    always_comb begin
        up_sum     = {1'b0, ftw_q} + {1'b0, step_q};
        up_word    = (up_sum >= {1'b0, stop_q}) ? stop_q : up_sum[FTW_W-1:0];
        degenerate = (step_q == '0) || (start_q >= stop_q);
        at_top     = (ftw_q == stop_q) || degenerate;
`ifdef NCO_SWEEP_PINGPONG_EN
        dn_diff = {1'b0, ftw_q} - {1'b0, step_q};
        dn_word = (dn_diff[FTW_W] || (dn_diff[FTW_W-1:0] <= start_q)) ? start_q
                                                                        : dn_diff[FTW_W-1:0];
`endif
    end

    // Sweep FSM next-state and datapath updates.
    always_comb begin
        state_d     = state_q;
        ftw_d       = ftw_q;
        cnt_d       = cnt_q;
        dwell_cnt_d = dwell_cnt_q;
        done_d      = 1'b0;
`ifdef NCO_SWEEP_PINGPONG_EN
        dir_down_d  = dir_down_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (load) begin
                    state_d = StWaitAck;
                    ftw_d   = ftw_start;
                    cnt_d   = '0;
`ifdef NCO_SWEEP_PINGPONG_EN
                    dir_down_d = 1'b0;
`endif
                end
            end
            StWaitAck: begin
                if (ftw_bus.ftw_ready) begin
                    state_d     = StDwell;
                    dwell_cnt_d = dwell_q;
                    cnt_d       = cnt_q + CNT_W'(1);
                end
            end
            StDwell: begin
                if (dwell_cnt_q != DWELL_W'(1)) begin
                    dwell_cnt_d = dwell_cnt_q - DWELL_W'(1);
                end else begin
                    state_d = StWaitAck;
`ifdef NCO_SWEEP_PINGPONG_EN
                    if (dir_down_q) begin
                        // Descending leg; turn back up once the start word has been emitted.
                        if (ftw_q == start_q) begin
                            dir_down_d = 1'b0;
                            ftw_d      = up_word;
                        end else begin
                            ftw_d = dn_word;
                        end
                    end else if (!at_top) begin
                        ftw_d = up_word;
                    end else if (cont_q && !degenerate) begin
                        dir_down_d = 1'b1;
                        ftw_d      = dn_word;
                    end else if (cont_q) begin
                        ftw_d = start_q;
                    end else begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end
`else
                    if (!at_top) begin
                        ftw_d = up_word;
                    end else if (cont_q) begin
                        ftw_d = start_q;
                    end else begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end
`endif
                end
            end
            default: state_d = StIdle;
        endcase

        // Abort wins over everything, including a same-cycle handshake; outputs hold.
        if (stop) begin
            state_d = StIdle;
            ftw_d   = ftw_q;
            cnt_d   = cnt_q;
            done_d  = 1'b0;
        end
    end

    // State and datapath registers.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q     <= StIdle;
            ftw_q       <= '0;
            cnt_q       <= '0;
            dwell_cnt_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ftw_q       <= ftw_d;
            cnt_q       <= cnt_d;
            dwell_cnt_q <= dwell_cnt_d;
            done_q      <= done_d;
        end
    end

`ifdef NCO_SWEEP_PINGPONG_EN
    // Sweep direction for the ping-pong continuous mode.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            dir_down_q <= 1'b0;
        end else begin
            dir_down_q <= dir_down_d;
        end
    end
`endif

    // Shadow programme registers; a zero dwell is stored as one.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            start_q <= '0;
            stop_q  <= '0;
            step_q  <= '0;
            dwell_q <= DWELL_W'(1);
            cont_q  <= 1'b0;
        end else if (load) begin
            start_q <= ftw_start;
            stop_q  <= ftw_stop;
            step_q  <= ftw_step;
            dwell_q <= (dwell == '0) ? DWELL_W'(1) : dwell;
            cont_q  <= continuous;
        end
    end

    assign ftw_bus.ftw_out   = ftw_q;
    assign ftw_bus.ftw_valid = (state_q == StWaitAck);
    assign busy              = (state_q != StIdle);
    assign done              = done_q;
    assign step_cnt          = cnt_q;

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Self-checking bench for nco_sweep_ctrl: directed programmes plus randomized ones, checked
// cycle by cycle against a word-list model and handshake/dwell timing rules.
module tb_nco_sweep_ctrl;

    localparam int unsigned FTW_W   = 32;
    localparam int unsigned DWELL_W = 24;
    localparam int unsigned CNT_W   = 16;

`ifdef NCO_SWEEP_PINGPONG_EN
    localparam bit PingPong = 1'b1;
`else
    localparam bit PingPong = 1'b0;
`endif

    logic               sys_clk = 1'b0;
    logic               sys_rst;
    logic               start;
    logic               stop;
    logic [FTW_W-1:0]   ftw_start;
    logic [FTW_W-1:0]   ftw_stop;
    logic [FTW_W-1:0]   ftw_step;
    logic [DWELL_W-1:0] dwell;
    logic               continuous;
    logic               busy;
    logic               done;
    logic [CNT_W-1:0]   step_cnt;

    nco_sweep_ctrl_if #(.FTW_W(FTW_W)) ftw_bus ();

    nco_sweep_ctrl #(
        .FTW_W   (FTW_W),
        .DWELL_W (DWELL_W),
        .CNT_W   (CNT_W)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .start      (start),
        .stop       (stop),
        .ftw_start  (ftw_start),
        .ftw_stop   (ftw_stop),
        .ftw_step   (ftw_step),
        .dwell      (dwell),
        .continuous (continuous),
        .ftw_bus    (ftw_bus.master),
        .busy       (busy),
        .done       (done),
        .step_cnt   (step_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    int         n_assert = 0;
    int         n_fail   = 0;
    longint     exp_words[$];
    longint     acc_words[$];
    int         acc_cyc[$];
    int         done_cyc;
    logic [31:0] last_word;
    logic [15:0] last_cnt;

`ifdef NCO_SWEEP_PINGPONG_EN
    longint cont_ref[8] = '{100, 110, 120, 130, 120, 110, 100, 110};
`else
    longint cont_ref[8] = '{100, 110, 120, 130, 100, 110, 120, 130};
`endif

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string tag, input string what, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s/%s: observed 0x%0h expected 0x%0h", tag, what, obs, exp);
        end
    endtask

    // Word sequence the sweep should hand over, from the programme rules alone.
    function automatic void gen_words(input longint s, input longint e, input longint st,
                                      input bit cont, input int n);
        longint w;
        bit     up;
        bit     degen;
        exp_words.delete();
        w     = s;
        up    = 1'b1;
        degen = (st == 0) || (s >= e);
        exp_words.push_back(w);
        while (exp_words.size() < n) begin
            if (up && (w == e || degen)) begin
                if (!cont) break;
                if (PingPong && !degen) begin
                    up = 1'b0;
                    w  = (w - st <= s) ? s : w - st;
                end else begin
                    w = s;
                end
            end else if (up) begin
                w = (w + st >= e) ? e : w + st;
            end else if (w == s) begin
                up = 1'b1;
                w  = (w + st >= e) ? e : w + st;
            end else begin
                w = (w - st <= s) ? s : w - st;
            end
            exp_words.push_back(w);
        end
    endfunction

    // rmode: 0 ready tied high, 1 random ready plus mid-sweep start/input noise,
    // 2 ready held low for 7 cycles on the second word. stop_at: cycle to abort (0 = never).
    task automatic run_sweep(input string tag, input logic [31:0] s, input logic [31:0] e,
                             input logic [31:0] st, input logic [23:0] dw, input bit cont,
                             input int rmode, input int stop_at);
        int          d;
        int          idx;
        int          k;
        int          resume_at;
        int          bp;
        int          mode;       // 0 running, 1 completed, 2 aborted
        bit          offering;
        bit          do_stop;
        bit          rdy;
        bit          exp_done;
        bit          finished;
        logic [15:0] cnt;

        d = (dw == 0) ? 1 : int'(dw);
        gen_words(longint'(s), longint'(e), longint'(st), cont, 400);
        acc_words.delete();
        acc_cyc.delete();
        done_cyc   = -1;
        ftw_start  = s;
        ftw_stop   = e;
        ftw_step   = st;
        dwell      = dw;
        continuous = cont;
        start      = 1'b1;
        tick();
        start     = 1'b0;
        k         = 0;
        idx       = 0;
        offering  = 1'b1;
        mode      = 0;
        cnt       = '0;
        bp        = 0;
        resume_at = 0;
        finished  = 1'b0;
        for (int guard = 0; guard < 4000; guard++) begin
            exp_done = 1'b0;
            if (mode == 0 && !offering && k == resume_at) begin
                if (idx == exp_words.size() - 1) begin
                    mode     = 1;
                    exp_done = 1'b1;
                    done_cyc = k;
                end else begin
                    idx++;
                    offering = 1'b1;
                end
            end
            chk(tag, "ftw_valid", ftw_bus.ftw_valid, (mode == 0) && offering);
            chk(tag, "busy", busy, mode == 0);
            chk(tag, "done", done, exp_done);
            chk(tag, "ftw_out", ftw_bus.ftw_out, exp_words[idx]);
            chk(tag, "step_cnt", step_cnt, cnt);
            if (mode != 0) begin
                finished = 1'b1;
                break;
            end
            do_stop = (stop_at > 0) && (k == stop_at);
            case (rmode)
                0: rdy = 1'b1;
                1: rdy = ($urandom_range(0, 3) != 0);
                default: begin
                    rdy = !(idx == 1 && offering && bp < 7);
                    if (!rdy) bp++;
                end
            endcase
            ftw_bus.ftw_ready = rdy;
            stop              = do_stop;
            if (rmode == 1 && !do_stop && $urandom_range(0, 5) == 0) begin
                start      = 1'b1;
                ftw_start  = $urandom;
                ftw_stop   = $urandom;
                ftw_step   = $urandom;
                dwell      = 24'($urandom);
                continuous = ~cont;
            end
            tick();
            k++;
            start = 1'b0;
            stop  = 1'b0;
            if (do_stop) begin
                mode = 2;
            end else if (offering && rdy) begin
                offering  = 1'b0;
                cnt++;
                acc_words.push_back(exp_words[idx]);
                acc_cyc.push_back(k);
                resume_at = k + d;
            end
        end
        chk(tag, "finished_within_budget", finished, 1'b1);
        // Done is a single-cycle pulse and the block stays idle with outputs held.
        ftw_bus.ftw_ready = 1'b1;
        tick();
        chk(tag, "post_done", done, 1'b0);
        chk(tag, "post_busy", busy, 1'b0);
        chk(tag, "post_valid", ftw_bus.ftw_valid, 1'b0);
        chk(tag, "post_ftw_out", ftw_bus.ftw_out, exp_words[idx]);
        chk(tag, "post_step_cnt", step_cnt, cnt);
        last_word = exp_words[idx][31:0];
        last_cnt  = cnt;
    endtask

    initial begin
        logic [31:0] rs;
        logic [31:0] re;
        logic [31:0] rst_w;
        bit          rc;
        int          rstop;

        sys_rst           = 1'b1;
        start             = 1'b0;
        stop              = 1'b0;
        ftw_start         = '0;
        ftw_stop          = '0;
        ftw_step          = '0;
        dwell             = '0;
        continuous        = 1'b0;
        ftw_bus.ftw_ready = 1'b1;
        repeat (3) tick();
        chk("reset", "ftw_out", ftw_bus.ftw_out, 0);
        chk("reset", "ftw_valid", ftw_bus.ftw_valid, 0);
        chk("reset", "busy", busy, 0);
        chk("reset", "done", done, 0);
        chk("reset", "step_cnt", step_cnt, 0);
        sys_rst = 1'b0;
        tick();

        // Basic sweep
        run_sweep("basic", 100, 130, 10, 3, 0, 0, 0);
        chk("basic", "n_words", acc_words.size(), 4);
        chk("basic", "w0", acc_words[0], 100);
        chk("basic", "w1", acc_words[1], 110);
        chk("basic", "w2", acc_words[2], 120);
        chk("basic", "w3", acc_words[3], 130);
        chk("basic", "spacing", acc_cyc[3] - acc_cyc[2], 4);
        chk("basic", "done_delay", done_cyc - acc_cyc[3], 3);
        chk("basic", "final_cnt", last_cnt, 4);

        // Clamp and overflow
        run_sweep("clamp", 100, 125, 10, 2, 0, 0, 0);
        chk("clamp", "n_words", acc_words.size(), 4);
        chk("clamp", "w3", acc_words[3], 125);
        run_sweep("ovf", 32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 1, 0, 0, 0);
        chk("ovf", "n_words", acc_words.size(), 2);
        chk("ovf", "w1", acc_words[1], 64'hFFFF_FFFF);

        // Backpressure on the second word
        run_sweep("bp", 100, 130, 10, 3, 0, 2, 0);
        chk("bp", "held_gap", acc_cyc[1] - acc_cyc[0], 11);
        chk("bp", "dwell_after_accept", acc_cyc[2] - acc_cyc[1], 4);

        // Abort during dwell
        run_sweep("abort", 100, 130, 10, 3, 0, 0, 2);
        chk("abort", "no_done", done_cyc, -1);
        chk("abort", "n_words", acc_words.size(), 1);

        // start and stop together from idle
        ftw_start = 500;
        ftw_stop  = 900;
        ftw_step  = 1;
        start     = 1'b1;
        stop      = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        chk("collide", "busy", busy, 0);
        chk("collide", "ftw_valid", ftw_bus.ftw_valid, 0);
        chk("collide", "ftw_out", ftw_bus.ftw_out, last_word);
        chk("collide", "step_cnt", step_cnt, last_cnt);
        tick();
        chk("collide", "still_idle", busy, 0);

        // Degenerate programmes and zero dwell
        run_sweep("step0", 200, 300, 0, 0, 0, 0, 0);
        chk("step0", "n_words", acc_words.size(), 1);
        chk("step0", "w0", acc_words[0], 200);
        chk("step0", "done_delay", done_cyc - acc_cyc[0], 1);
        run_sweep("inverted", 200, 100, 10, 2, 0, 0, 0);
        chk("inverted", "n_words", acc_words.size(), 1);
        chk("inverted", "w0", acc_words[0], 200);
        run_sweep("dwell0", 100, 130, 10, 0, 0, 0, 0);
        chk("dwell0", "spacing", acc_cyc[1] - acc_cyc[0], 2);

        // Continuous mode
        run_sweep("cont", 100, 130, 10, 2, 1, 0, 40);
        chk("cont", "no_done", done_cyc, -1);
        for (int i = 0; i < 8; i++) begin
            chk("cont", $sformatf("w%0d", i), acc_words[i], cont_ref[i]);
        end

        // Reset mid-sweep
        ftw_start  = 1000;
        ftw_stop   = 2000;
        ftw_step   = 100;
        dwell      = 5;
        continuous = 1'b0;
        start      = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        sys_rst = 1'b1;
        tick();
        chk("midreset", "ftw_out", ftw_bus.ftw_out, 0);
        chk("midreset", "ftw_valid", ftw_bus.ftw_valid, 0);
        chk("midreset", "busy", busy, 0);
        chk("midreset", "done", done, 0);
        chk("midreset", "step_cnt", step_cnt, 0);
        sys_rst = 1'b0;
        tick();
        chk("midreset", "idle_after", busy, 0);

        // Randomized programmes with random ready, aborts and mid-sweep start noise
        for (int r = 0; r < 8; r++) begin
            rs    = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 500))
                                                : (32'hFFFF_FF00 | 32'($urandom_range(0, 255)));
            re    = rs + 32'($urandom_range(0, 300));
            rst_w = ($urandom_range(0, 4) == 0) ? 32'd0 : 32'($urandom_range(10, 80));
            rc    = 1'($urandom_range(0, 1));
            if (rc) rstop = $urandom_range(5, 60);
            else    rstop = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 40);
            run_sweep($sformatf("rand%0d", r), rs, re, rst_w, 24'($urandom_range(0, 4)), rc, 1,
                      rstop);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
